// File: rtl/trisc_sequencer.sv
// TRISC fetch/decode/execute sequencer: decodes opcodes into control strobes, counts retired instructions.
// Latency: 3 cycles per instruction (FETCH, DECODE, EXEC) plus one per memory wait cycle; mem_rd/mem_wr hold until mem_ready.
module trisc_sequencer #(
    parameter int OPW   = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             step,
    input  logic [OPW-1:0]   opcode,
    input  logic             zf,
    input  logic             nf,
    input  logic             mem_ready,
    output logic             addr_sel,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             ir_ld,
    output logic             pc_inc,
    output logic             pc_ld,
    output logic             acc_ld,
    output logic [2:0]       alu_op,
    output logic             halted,
    output logic             illegal,
    output logic             busy,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    localparam int I_LDA = 0;
    localparam int I_STA = 1;
    localparam int I_ADD = 2;
    localparam int I_SUB = 3;
    localparam int I_XOR = 4;
    localparam int I_INC = 5;
    localparam int I_CLR = 6;
    localparam int I_JMP = 7;
    localparam int I_JPN = 8;
    localparam int I_JPZ = 9;
    localparam int I_HLT = 10;
    localparam int I_ILL = 11;
    localparam int NI    = 12;

    state_t           state_q, state_d;
    logic [NI-1:0]    ins_q, ins_d;
    logic             zf_q, zf_d;
    logic             nf_q, nf_d;
    logic             halted_q, halted_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NI-1:0]    dec;
    logic             hi_bits;
    logic             mem_cls;
    logic             exec_done;

    // One-hot opcode decode; any set bit above the 4-bit map makes it illegal.
    always_comb begin
        dec     = '0;
        hi_bits = 1'b0;
        for (int i = 4; i < OPW; i++) begin
            hi_bits = hi_bits | opcode[i];
        end
        if (hi_bits) begin
            dec[I_ILL] = 1'b1;
        end else begin
            case (opcode[3:0])
                4'h0:    dec[I_LDA] = 1'b1;
                4'h1:    dec[I_STA] = 1'b1;
                4'h2:    dec[I_ADD] = 1'b1;
                4'h3:    dec[I_SUB] = 1'b1;
                4'h4:    dec[I_XOR] = 1'b1;
                4'h6:    dec[I_INC] = 1'b1;
                4'h7:    dec[I_CLR] = 1'b1;
                4'h8:    dec[I_JMP] = 1'b1;
                4'h9:    dec[I_JPN] = 1'b1;
                4'hC:    dec[I_JPZ] = 1'b1;
                4'hF:    dec[I_HLT] = 1'b1;
                default: dec[I_ILL] = 1'b1;
            endcase
        end
    end

    assign mem_cls   = ins_q[I_LDA] | ins_q[I_ADD] | ins_q[I_SUB] | ins_q[I_XOR];
    assign exec_done = (mem_cls | ins_q[I_STA]) ? mem_ready : 1'b1;

    always_comb begin
        state_d   = state_q;
        ins_d     = ins_q;
        zf_d      = zf_q;
        nf_d      = nf_q;
        halted_d  = halted_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (run || step) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ins_d   = dec;
                zf_d    = zf;
                nf_d    = nf;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (exec_done) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (ins_q[I_ILL]) illegal_d = 1'b1;
                    if (ins_q[I_HLT]) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        state_d = run ? S_FETCH : S_IDLE;
                    end
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ins_q     <= '0;
            zf_q      <= 1'b0;
            nf_q      <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ins_q     <= ins_d;
            zf_q      <= zf_d;
            nf_q      <= nf_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    // Strobes come only from registered state and the instruction latch; mem_ready gates completion.
    always_comb begin
        addr_sel = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        ir_ld    = 1'b0;
        pc_inc   = 1'b0;
        pc_ld    = 1'b0;
        acc_ld   = 1'b0;
        alu_op   = 3'd0;
        if (state_q == S_FETCH) begin
            mem_rd = 1'b1;
            ir_ld  = mem_ready;
            pc_inc = mem_ready;
        end else if (state_q == S_EXEC) begin
            addr_sel = mem_cls | ins_q[I_STA];
            mem_rd   = mem_cls;
            mem_wr   = ins_q[I_STA];
            acc_ld   = (mem_cls & mem_ready) | ins_q[I_INC] | ins_q[I_CLR];
            pc_ld    = ins_q[I_JMP] | (ins_q[I_JPZ] & zf_q) | (ins_q[I_JPN] & nf_q);
            if (ins_q[I_ADD])      alu_op = 3'd1;
            else if (ins_q[I_SUB]) alu_op = 3'd2;
            else if (ins_q[I_XOR]) alu_op = 3'd3;
            else if (ins_q[I_INC]) alu_op = 3'd4;
            else if (ins_q[I_CLR]) alu_op = 3'd5;
        end
    end

    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign instr_count = cnt_q;

endmodule

// File: doc/trisc_sequencer.md
# trisc_sequencer

Parametrised TRISC control sequencer that replaces the purely combinational opcode decoder. It owns the fetch/decode/execute state machine, decodes opcodes into registered control strobes, and adds several capabilities:
- memory wait-state handshake
- conditional-jump resolution from accumulator flags
- run/single-step modes
- sticky illegal-opcode flag
- halt latch
- retired-instruction counter

It sits between the instruction register/flag logic and the TRISC datapath (PC, MAR, accumulator, ALU, memory).

## Interface
- OPW, 4: opcode width; opcode map below occupies low 4 bits, any nonzero bit above bit 3 is illegal
- CNT_W, 16: retired-instruction counter width
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- run  in  1  level; high = free-run
- step  in  1  level; sampled only in IDLE while run low, executes one instruction
- opcode  in  OPW  IR opcode field, sampled in DECODE
- zf, nf  in  1  accumulator zero/negative flags, sampled in DECODE
- mem_ready  in  1  memory completes current read/write this cycle
- addr_sel  out  1  0 = PC drives address, 1 = IR operand drives address
- mem_rd, mem_wr  out  1  memory read/write request
- ir_ld  out  1  load IR from memory data
- pc_inc  out  1  PC <= PC+1
- pc_ld  out  1  PC <= IR operand (jump taken)
- acc_ld  out  1  accumulator <= ALU result
- alu_op  out  3  0 PASS, 1 ADD, 2 SUB, 3 XOR, 4 INC, 5 CLR
- halted  out  1  sticky, HLT executed
- illegal  out  1  sticky, illegal opcode decoded
- busy  out  1  state != IDLE and != HALT
- instr_count  out  CNT_W  retired instructions

## Operation
- Opcode map:
  - 0 LDA
  - 1 STA
  - 2 ADD
  - 3 SUB
  - 4 XOR
  - 6 INC
  - 7 CLR
  - 8 JMP
  - 9 JPN (jump if nf)
  - C JPZ (jump if zf)
  - F HLT
  - 5, A, B, D, E illegal
- States: IDLE, FETCH, DECODE, EXEC, HALT.
- IDLE → FETCH when run=1, or when step=1 with run=0 (single-step).
- FETCH: addr_sel=0, mem_rd=1. Hold until mem_ready. On the ready cycle ir_ld=1 and pc_inc=1, then → DECODE.
- DECODE: one cycle. Registers the one-hot decode of opcode, plus zf/nf, into an internal instruction latch. No strobes asserted. → EXEC.
- EXEC strobes:
  - LDA/ADD/SUB/XOR: addr_sel=1, mem_rd=1, alu_op per map. Hold until mem_ready; acc_ld=1 on the ready cycle only.
  - STA: addr_sel=1, mem_wr=1. Hold until mem_ready.
  - INC/CLR: acc_ld=1, alu_op 4/5, single cycle.
  - JMP: pc_ld=1, single cycle. JPZ/JPN: pc_ld = latched zf/nf, single cycle.
  - HLT: halted<=1, → HALT.
  - Illegal: illegal<=1, no strobes, single cycle. Treated as a NOP.
- EXEC completion:
  - instr_count += 1, wrapping from all-ones to 0; HLT also counts.
  - Then → FETCH if run=1, else → IDLE.
  - run dropping mid-instruction never aborts the instruction.
- HALT: absorbing; only reset exits. All strobes stay 0.
- mem_rd/mem_wr stay asserted with a stable address while mem_ready=0. There is no timeout.

## Timing
- Reset (asynchronous, immediate, including mid-instruction):
  - state=IDLE
  - all strobes 0, alu_op=0
  - halted=0, illegal=0, busy=0, instr_count=0
- All outputs are registered or decoded from registered state only. There is no combinational path from opcode/zf/nf to outputs.
- mem_ready feeds ir_ld, pc_inc and acc_ld combinationally in the completing cycle.
- Latency with mem_ready tied high:
  - non-memory instruction: 3 cycles (FETCH, DECODE, EXEC)
  - memory instruction: 3 cycles
  - each wait cycle adds 1
- Free-run throughput: one instruction per 3 cycles; the EXEC → FETCH transition has no IDLE bubble.
- Single-step: step held high re-triggers on every return to IDLE. The bench pulses step for 1 cycle.
- opcode/zf/nf changes outside DECODE have no effect on the current instruction.

## Test plan
- Reset, then run=1, mem_ready=1, opcode=6 (INC): FETCH/DECODE/EXEC repeat every 3 cycles. acc_ld=1 with alu_op=4 every third cycle; instr_count reaches 4 after 12 cycles.
- Opcode=2 (ADD), mem_ready low for 2 EXEC cycles: mem_rd and addr_sel=1 held 3 cycles, acc_ld=1 only on the third, alu_op=1 throughout.
- JPZ (C) with zf=1 at DECODE then zf=0 during EXEC: pc_ld=1. JPN (9) with nf=0: pc_ld=0, count still increments.
- Opcode=5, then 4'hF: illegal=1 with no strobes for the opcode-5 instruction. Then halted=1, busy=0, and the state stays HALT for 20 cycles despite run=1; instr_count=2.
- run=0, 1-cycle step pulse, opcode=7: exactly one CLR executes (acc_ld, alu_op=5), then IDLE and busy=0.
- Assert reset_n low mid-EXEC of STA with mem_ready=0: mem_wr drops to 0 immediately. All outputs return to reset values; counter=0.
